gpio_cmd_bridge: RTL and testbench
==================================

// Module: gpio_cmd_bridge
// PURPOSE
//  Upstream front end of experiment_top_level's GPIO control path. Turns the host's slow GPIO bus
//  (addr/data plus a software-toggled w_clk strobe) into single-cycle register write/read commands
//  with valid/ready handshakes. Assembles 16-bit words from byte pairs and returns read data and
//  status on gpio_out_bus.
// PARAMETERS
//  SYNC_STAGES  2          flops on the w_clk strobe before edge detection (>=2)
//  RD_TIMEOUT   64         cycles RD_WAIT waits for rd_resp_valid before aborting
//  CLR_ADDR     16'h7FFF   write to this address clears all sticky status bits
// PORTS
//  clk            in   1    system clock
//  rst            in   1    synchronous reset, active-high
//  gpio_in        in   32   [7:0] data, [23:8] addr, [30:24] ignored, [31] w_clk strobe
//  gpio_out_bus   out  32   [15:0] last read data, [23:16] read count, [24] busy,
//                           [25] ovf, [26] pair_err, [27] rd_timeout, [31:28] 0
//  wr_valid       out  1    write command valid
//  wr_ready       in   1    downstream accepts write
//  wr_addr        out  15   register address (addr[14:0])
//  wr_data        out  16   assembled word {first byte, second byte}
//  rd_req_valid   out  1    read request valid
//  rd_req_ready   in   1    downstream accepts read request
//  rd_req_addr    out  15   register address to read (addr[14:0])
//  rd_resp_valid  in   1    read data valid (single-cycle pulse)
//  rd_resp_data   in   16   read data
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, byte phase = FIRST, counters and stickies 0.
//  - Strobe: gpio_in[31] passes through SYNC_STAGES flops, then rise detect (sync & ~sync_d).
//    addr/data are captured from gpio_in in the rise-detect cycle. The host holds them stable
//    for >=7 cycles. A falling edge has no effect.
//  - Decode on a rise:
//    - addr==CLR_ADDR: clear [27:25] next cycle. No command issued. Phase reset to FIRST.
//    - addr[15]=1: read command, single byte, data ignored. Phase reset to FIRST.
//    - else: write byte.
//      - Phase FIRST: latch hi byte and addr, go to SECOND.
//      - Phase SECOND with same addr: issue write {hi,data}, go to FIRST.
//      - Phase SECOND with different addr: set pair_err, drop the held byte, treat the current
//        byte as a new FIRST.
//  - FSM states:
//    - IDLE. A completed write goes to WR_OUT. A read command goes to RD_REQ.
//    - WR_OUT: wr_valid=1 with addr/data held stable until wr_valid&wr_ready, then IDLE.
//    - RD_REQ: rd_req_valid=1 until rd_req_valid&rd_req_ready, then RD_WAIT. Load timeout counter.
//    - RD_WAIT: on rd_resp_valid, latch data into [15:0], increment [23:16] (wraps 255->0), go IDLE.
//      If RD_TIMEOUT cycles pass with no response: [15:0]=16'hDEAD, set [27], increment count, IDLE.
//      If rd_resp_valid arrives in the same cycle the counter expires, the response wins.
//  - busy [24] = FSM != IDLE.
//  - A command decoded while FSM != IDLE is dropped and sets ovf [25].
//    - CLR_ADDR writes are never dropped.
//    - First-byte latching still occurs while busy (no command issued).
//  - Latency: wr_valid rises SYNC_STAGES+2 cycles after the first clk edge that samples w_clk=1.
//  - Sticky bits [27:25] set only. Cleared only by CLR_ADDR or rst. A set and a clear in the
//    same cycle: set wins.
//  - rst mid-transaction: valids drop the next cycle, pending byte discarded, no stale command
//    issued afterwards.
//  - rd_resp_valid outside RD_WAIT is ignored.
// TESTING
//  1. Write pair: addr 0x0001, bytes 0x12 then 0x34, wr_ready=1 -> one wr_valid pulse,
//     wr_addr=0x0001, wr_data=0x1234, 4 cycles after strobe.
//  2. Backpressure: wr_ready=0 for 20 cycles -> wr_valid/addr/data stable, busy=1. A strobe
//     during this time sets ovf. Release -> single accept.
//  3. Read: addr 0x8003. Responder returns 0xBEEF 3 cycles after accept ->
//     gpio_out_bus[15:0]=0xBEEF, [23:16]=1, rd_req_addr=0x0003.
//  4. Timeout: read with no responder -> after 64 cycles [15:0]=0xDEAD, [27]=1. Write CLR_ADDR
//     -> [27:25]=0.
//  5. Pair error: byte to 0x0002, then byte to 0x0005, then byte to 0x0005 -> pair_err=1, one
//     write addr 0x0005 only.
//  6. Reset: assert rst while in WR_OUT -> wr_valid=0 next cycle, then 256 reads show the count
//     wrapping to 0.

Source files
------------

// File: rtl/gpio_cmd_bridge.sv
// gpio_cmd_bridge: turns the host's strobed GPIO bus into register
// write/read commands with valid/ready handshakes and status readback.
module gpio_cmd_bridge #(
  parameter int          SYNC_STAGES = 2,
  parameter int          RD_TIMEOUT  = 64,
  parameter logic [15:0] CLR_ADDR    = 16'h7FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out_bus,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [14:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  output logic [14:0] rd_req_addr,
  input  logic        rd_resp_valid,
  input  logic [15:0] rd_resp_data
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WR_OUT,
    RD_REQ,
    RD_WAIT
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   strb_d_q;
  logic                   rise;

  logic        cap_vld_q;
  logic [15:0] cap_addr_q;
  logic [7:0]  cap_data_q;

  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [14:0] hold_q, hold_d;
  logic        wr_cmd_q, wr_cmd_d;
  logic        rd_cmd_q, rd_cmd_d;
  logic        clr_q, clr_d;
  logic        pair_q, pair_d;
  logic [14:0] cmd_addr_q, cmd_addr_d;
  logic [15:0] cmd_data_q, cmd_data_d;

  state_e      state_q;
  logic        wr_valid_q;
  logic [14:0] wr_addr_q;
  logic [15:0] wr_data_q;
  logic        rd_req_valid_q;
  logic [14:0] rd_req_addr_q;
  logic [TW-1:0] tmo_q;
  logic [15:0] rd_data_q;
  logic [7:0]  rd_cnt_q;
  logic        busy_q;
  logic [2:0]  stk_q;
  logic        to_hit;
  logic        ovf_hit;
  logic        unused_gpio;

  assign unused_gpio = ^gpio_in[30:24];

  assign rise = sync_q[SYNC_STAGES-1] & ~strb_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      strb_d_q   <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_addr_q <= '0;
      cap_data_q <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], gpio_in[31]};
      strb_d_q  <= sync_q[SYNC_STAGES-1];
      cap_vld_q <= rise;
      if (rise) begin
        cap_addr_q <= gpio_in[23:8];
        cap_data_q <= gpio_in[7:0];
      end
    end
  end

  always_comb begin
    phase_d    = phase_q;
    hi_d       = hi_q;
    hold_d     = hold_q;
    wr_cmd_d   = 1'b0;
    rd_cmd_d   = 1'b0;
    clr_d      = 1'b0;
    pair_d     = 1'b0;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    if (cap_vld_q) begin
      if (cap_addr_q == CLR_ADDR) begin
        clr_d   = 1'b1;
        phase_d = 1'b0;
      end else if (cap_addr_q[15]) begin
        rd_cmd_d   = 1'b1;
        cmd_addr_d = cap_addr_q[14:0];
        phase_d    = 1'b0;
      end else if (!phase_q) begin
        phase_d = 1'b1;
        hi_d    = cap_data_q;
        hold_d  = cap_addr_q[14:0];
      end else if (cap_addr_q[14:0] == hold_q) begin
        wr_cmd_d   = 1'b1;
        cmd_addr_d = hold_q;
        cmd_data_d = {hi_q, cap_data_q};
        phase_d    = 1'b0;
      end else begin
        // mismatched second byte restarts the pair with itself as the high byte
        pair_d = 1'b1;
        hi_d   = cap_data_q;
        hold_d = cap_addr_q[14:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= 1'b0;
      hi_q       <= '0;
      hold_q     <= '0;
      wr_cmd_q   <= 1'b0;
      rd_cmd_q   <= 1'b0;
      clr_q      <= 1'b0;
      pair_q     <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
    end else begin
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      hold_q     <= hold_d;
      wr_cmd_q   <= wr_cmd_d;
      rd_cmd_q   <= rd_cmd_d;
      clr_q      <= clr_d;
      pair_q     <= pair_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
    end
  end

  assign to_hit  = (state_q == RD_WAIT) && !rd_resp_valid
                   && (tmo_q == '0);
  assign ovf_hit = (wr_cmd_q || rd_cmd_q) && (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_valid_q     <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      rd_req_valid_q <= 1'b0;
      rd_req_addr_q  <= '0;
      tmo_q          <= '0;
      rd_data_q      <= '0;
      rd_cnt_q       <= '0;
      busy_q         <= 1'b0;
      stk_q          <= '0;
    end else begin
      // a set in the same cycle as a clear survives
      stk_q <= (clr_q ? 3'b000 : stk_q) | {to_hit, pair_q, ovf_hit};
      unique case (state_q)
        IDLE: begin
          if (wr_cmd_q) begin
            state_q    <= WR_OUT;
            wr_valid_q <= 1'b1;
            wr_addr_q  <= cmd_addr_q;
            wr_data_q  <= cmd_data_q;
            busy_q     <= 1'b1;
          end else if (rd_cmd_q) begin
            state_q        <= RD_REQ;
            rd_req_valid_q <= 1'b1;
            rd_req_addr_q  <= cmd_addr_q;
            busy_q         <= 1'b1;
          end
        end
        WR_OUT: begin
          if (wr_ready) begin
            state_q    <= IDLE;
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        RD_REQ: begin
          if (rd_req_ready) begin
            state_q        <= RD_WAIT;
            rd_req_valid_q <= 1'b0;
            tmo_q          <= TW'(RD_TIMEOUT - 1);
          end
        end
        RD_WAIT: begin
          if (rd_resp_valid) begin
            rd_data_q <= rd_resp_data;
            rd_cnt_q  <= rd_cnt_q + 8'd1;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else if (tmo_q == '0) begin
            rd_data_q <= 16'hDEAD;
            rd_cnt_q  <= rd_cnt_q + 8'd1;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else begin
            tmo_q <= tmo_q - TW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign rd_req_valid = rd_req_valid_q;
  assign rd_req_addr  = rd_req_addr_q;
  assign gpio_out_bus = {4'h0, stk_q, busy_q, rd_cnt_q, rd_data_q};

endmodule

// File: tb/tb_gpio_cmd_bridge.sv
// tb_gpio_cmd_bridge: randomized host-strobe stimulus checked against a
// transaction-level model of the GPIO command bridge.
module tb_gpio_cmd_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out_bus;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [14:0] rd_req_addr;
  logic        rd_resp_valid;
  logic [15:0] rd_resp_data;

  always #5 clk = ~clk;

  gpio_cmd_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .gpio_in      (gpio_in),
    .gpio_out_bus (gpio_out_bus),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_resp_valid(rd_resp_valid),
    .rd_resp_data (rd_resp_data)
  );

  int checks = 0;
  int errors = 0;

  logic        resp_en;
  logic [15:0] resp_data;
  logic [14:0] last_rd_addr;
  int          stray_req  = 0;
  int          stray_done = 0;

  logic [30:0] wr_log[$];
  int          wr_idx = 0;

  bit          m_phase;
  logic [7:0]  m_hi;
  logic [14:0] m_haddr;
  logic [2:0]  m_stk;
  logic [7:0]  m_cnt;
  logic [15:0] m_data;
  bit          m_busy;
  logic [30:0] exp_wr[$];

  always @(posedge clk)
    if (!rst && wr_valid && wr_ready)
      wr_log.push_back({wr_addr, wr_data});

  initial begin
    rd_resp_valid = 1'b0;
    rd_resp_data  = '0;
    last_rd_addr  = '0;
    forever begin
      @(negedge clk);
      if (!rst && rd_req_valid && rd_req_ready && resp_en) begin
        last_rd_addr = rd_req_addr;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rd_resp_valid = 1'b1;
        rd_resp_data  = resp_data;
        @(negedge clk);
        rd_resp_valid = 1'b0;
      end else if (stray_req != stray_done) begin
        rd_resp_valid = 1'b1;
        rd_resp_data  = 16'h1111;
        @(negedge clk);
        rd_resp_valid = 1'b0;
        stray_done    = stray_req;
      end
    end
  end

  function automatic logic [31:0] m_bus();
    return {4'h0, m_stk, 1'b0, m_cnt, m_data};
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_hi    = '0;
    m_haddr = '0;
    m_stk   = '0;
    m_cnt   = '0;
    m_data  = '0;
    m_busy  = 0;
    exp_wr.delete();
  endtask

  task automatic model_strobe(input logic [15:0] a, input logic [7:0] d);
    if (a == 16'h7FFF) begin
      m_stk   = '0;
      m_phase = 0;
    end else if (a[15]) begin
      m_phase = 0;
      if (m_busy) m_stk[0] = 1'b1;
      else begin
        m_cnt = m_cnt + 8'd1;
        if (resp_en) m_data = resp_data;
        else begin
          m_data   = 16'hDEAD;
          m_stk[2] = 1'b1;
        end
      end
    end else if (!m_phase) begin
      m_phase = 1;
      m_hi    = d;
      m_haddr = a[14:0];
    end else if (a[14:0] == m_haddr) begin
      m_phase = 0;
      if (m_busy) m_stk[0] = 1'b1;
      else exp_wr.push_back({m_haddr, m_hi, d});
    end else begin
      m_stk[1] = 1'b1;
      m_hi     = d;
      m_haddr  = a[14:0];
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [7:0] d);
    model_strobe(a, d);
    @(negedge clk);
    gpio_in = {1'b1, 7'h0, a, d};
    repeat (8) @(negedge clk);
    gpio_in[31] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    gpio_in      = '0;
    wr_ready     = 1'b1;
    rd_req_ready = 1'b1;
    resp_en      = 1'b1;
    resp_data    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({gpio_out_bus, wr_valid, rd_req_valid} !== 34'h0) begin
      errors++;
      $display("FAIL reset_outputs: got bus=%h wv=%b rv=%b want 0",
               gpio_out_bus, wr_valid, rd_req_valid);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_pair();
    int k;
    bit got;
    int n;
    send(16'h0001, 8'h12);
    model_strobe(16'h0001, 8'h34);
    @(negedge clk);
    gpio_in = {1'b1, 7'h0, 16'h0001, 8'h34};
    @(posedge clk);
    k   = 0;
    got = 0;
    while (!got && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      got = wr_valid;
    end
    checks++;
    if (!got || k != 4) begin
      errors++;
      $display("FAIL wr_latency: got %0d cycles (seen=%b) want 4", k, got);
    end
    checks++;
    if (wr_addr !== 15'h0001 || wr_data !== 16'h1234) begin
      errors++;
      $display("FAIL wr_fields: got %h/%h want 0001/1234", wr_addr, wr_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_single_pulse: got wr_valid=%b want 0", wr_valid);
    end
    repeat (8) @(negedge clk);
    gpio_in[31] = 1'b0;
    repeat (8) @(negedge clk);
    n = wr_log.size() - wr_idx;
    checks++;
    if (n != exp_wr.size()) begin
      errors++;
      $display("FAIL wr_count: got %0d want %0d", n, exp_wr.size());
    end
    for (int i = 0; i < n && i < exp_wr.size(); i++) begin
      checks++;
      if (wr_log[wr_idx+i] !== exp_wr[i]) begin
        errors++;
        $display("FAIL wr_entry: got %h want %h", wr_log[wr_idx+i], exp_wr[i]);
      end
    end
    wr_idx = wr_log.size();
    exp_wr.delete();
  endtask

  task automatic test_backpressure();
    logic [14:0] a0;
    logic [15:0] d0;
    bit stable;
    int n;
    @(negedge clk);
    wr_ready = 1'b0;
    send(16'h0010, 8'hAB);
    send(16'h0010, 8'hCD);
    a0 = wr_addr;
    d0 = wr_data;
    m_busy = 1;
    send(16'h8004, 8'h00);
    m_busy = 0;
    stable = wr_valid && gpio_out_bus[24];
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (!wr_valid || wr_addr !== a0 || wr_data !== d0 || !gpio_out_bus[24])
        stable = 0;
    end
    checks++;
    if (!stable || a0 !== 15'h0010 || d0 !== 16'hABCD) begin
      errors++;
      $display("FAIL bp_hold: got stable=%b %h/%h want 1 0010/abcd",
               stable, a0, d0);
    end
    checks++;
    if (gpio_out_bus[25] !== 1'b1) begin
      errors++;
      $display("FAIL bp_ovf: got %b want 1", gpio_out_bus[25]);
    end
    @(negedge clk);
    wr_ready = 1'b1;
    repeat (4) @(negedge clk);
    n = wr_log.size() - wr_idx;
    checks++;
    if (n != 1 || exp_wr.size() != 1 || wr_log[wr_idx] !== exp_wr[0]) begin
      errors++;
      $display("FAIL bp_accept: got %0d writes first=%h want 1 of %h",
               n, wr_log[wr_idx], exp_wr[0]);
    end
    wr_idx = wr_log.size();
    exp_wr.delete();
    checks++;
    if (gpio_out_bus !== m_bus()) begin
      errors++;
      $display("FAIL bp_status: got %h want %h", gpio_out_bus, m_bus());
    end
    send(16'h7FFF, 8'h00);
    checks++;
    if (gpio_out_bus !== m_bus()) begin
      errors++;
      $display("FAIL bp_clear: got %h want %h", gpio_out_bus, m_bus());
    end
  endtask

  task automatic test_read();
    resp_en   = 1'b1;
    resp_data = 16'hBEEF;
    send(16'h8003, 8'h00);
    checks++;
    if (last_rd_addr !== 15'h0003) begin
      errors++;
      $display("FAIL rd_addr: got %h want 0003", last_rd_addr);
    end
    checks++;
    if (gpio_out_bus[23:0] !== 24'h01BEEF) begin
      errors++;
      $display("FAIL rd_data_cnt: got %h want 01beef", gpio_out_bus[23:0]);
    end
    for (int i = 0; i < 4; i++) begin
      resp_data = 16'($urandom);
      send({1'b1, 15'($urandom)}, 8'($urandom));
      checks++;
      if (gpio_out_bus !== m_bus()) begin
        errors++;
        $display("FAIL rd_rand: got %h want %h", gpio_out_bus, m_bus());
      end
    end
  endtask

  task automatic test_timeout();
    bit got;
    int n;
    int k;
    logic [31:0] snap;
    resp_en = 1'b0;
    model_strobe(16'h8007, 8'h00);
    @(negedge clk);
    gpio_in = {1'b1, 7'h0, 16'h8007, 8'h00};
    got = 0;
    k   = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      got = rd_req_valid;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL to_req: got no rd_req_valid want 1");
    end
    @(posedge clk);
    #1;
    n = 0;
    while (gpio_out_bus[24] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL to_cycles: got %0d want 64", n);
    end
    @(negedge clk);
    gpio_in[31] = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (gpio_out_bus !== m_bus() || gpio_out_bus[27] !== 1'b1) begin
      errors++;
      $display("FAIL to_status: got %h want %h", gpio_out_bus, m_bus());
    end
    snap = gpio_out_bus;
    stray_req++;
    repeat (4) @(negedge clk);
    checks++;
    if (gpio_out_bus !== snap) begin
      errors++;
      $display("FAIL stray_resp: got %h want %h", gpio_out_bus, snap);
    end
    resp_en = 1'b1;
    send(16'h7FFF, 8'h5A);
    checks++;
    if (gpio_out_bus[27:25] !== 3'b000 || gpio_out_bus !== m_bus()) begin
      errors++;
      $display("FAIL to_clear: got %h want %h", gpio_out_bus, m_bus());
    end
  endtask

  task automatic test_pair_err();
    int n;
    send(16'h0002, 8'h11);
    send(16'h0005, 8'h22);
    send(16'h0005, 8'h33);
    checks++;
    if (gpio_out_bus[26] !== 1'b1) begin
      errors++;
      $display("FAIL pair_flag: got %b want 1", gpio_out_bus[26]);
    end
    n = wr_log.size() - wr_idx;
    checks++;
    if (n != 1 || wr_log[wr_idx] !== {15'h0005, 16'h2233}) begin
      errors++;
      $display("FAIL pair_write: got %0d writes first=%h want 1 of 0005/2233",
               n, wr_log[wr_idx]);
    end
    wr_idx = wr_log.size();
    exp_wr.delete();
    send(16'h7FFF, 8'h00);
  endtask

  task automatic test_random_ops();
    int op;
    int n;
    logic [15:0] a;
    for (int t = 0; t < 24; t++) begin
      op = $urandom_range(0, 3);
      a  = 16'($urandom_range(0, 16'h7FFE));
      if (op <= 1) begin
        send(a, 8'($urandom));
        send(a, 8'($urandom));
      end else if (op == 2) begin
        send(a, 8'($urandom));
      end else begin
        resp_data = 16'($urandom);
        send({1'b1, a[14:0]}, 8'($urandom));
      end
      n = wr_log.size() - wr_idx;
      checks++;
      if (n != exp_wr.size()) begin
        errors++;
        $display("FAIL rand_wr_count: got %0d want %0d", n, exp_wr.size());
      end
      for (int i = 0; i < n && i < exp_wr.size(); i++) begin
        checks++;
        if (wr_log[wr_idx+i] !== exp_wr[i]) begin
          errors++;
          $display("FAIL rand_wr: got %h want %h", wr_log[wr_idx+i], exp_wr[i]);
        end
      end
      wr_idx = wr_log.size();
      exp_wr.delete();
      checks++;
      if (gpio_out_bus !== m_bus()) begin
        errors++;
        $display("FAIL rand_status: got %h want %h", gpio_out_bus, m_bus());
      end
    end
    send(16'h7FFF, 8'h00);
  endtask

  task automatic test_reset_mid_and_wrap();
    bit got;
    int k;
    send(16'h0020, 8'h55);
    @(negedge clk);
    wr_ready = 1'b0;
    gpio_in  = {1'b1, 7'h0, 16'h0020, 8'h66};
    got = 0;
    k   = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      got = wr_valid;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rst_reach_wr: got no wr_valid want 1");
    end
    gpio_in = '0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (wr_valid !== 1'b0 || gpio_out_bus !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: got wv=%b bus=%h want 0/0", wr_valid, gpio_out_bus);
    end
    @(negedge clk);
    rst      = 1'b0;
    wr_ready = 1'b1;
    model_reset();
    repeat (30) @(negedge clk);
    checks++;
    if (wr_log.size() != wr_idx || wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_stale: got %0d writes wv=%b want 0/0",
               wr_log.size() - wr_idx, wr_valid);
    end
    wr_idx  = wr_log.size();
    resp_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      resp_data = 16'($urandom);
      send({1'b1, 15'($urandom)}, 8'h00);
      if (i == 254) begin
        checks++;
        if (gpio_out_bus[23:16] !== 8'd255) begin
          errors++;
          $display("FAIL cnt_255: got %0d want 255", gpio_out_bus[23:16]);
        end
      end
    end
    checks++;
    if (gpio_out_bus[23:16] !== 8'd0 || gpio_out_bus !== m_bus()) begin
      errors++;
      $display("FAIL cnt_wrap: got %h want %h", gpio_out_bus, m_bus());
    end
  endtask

  initial begin
    test_reset();
    test_write_pair();
    test_backpressure();
    test_read();
    test_timeout();
    test_pair_err();
    test_random_ops();
    test_reset_mid_and_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
